// File: rtl/width_conv_16to8.sv
// Splits 16-bit FWFT words into low-then-high bytes and groups them into packets of PKT_WORDS words.
// Define WCONV_CHECKSUM_EN to append a 16-bit sum-of-words trailer (low byte first) to each packet.
module width_conv_16to8 #(
  parameter int unsigned PKT_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] din,
  input  logic        empty,
  output logic        rd_en,
  output logic [7:0]  dout,
  output logic        wr_en,
  input  logic        full,
  output logic        pkt_end,
  input  logic [7:0]  app_mode,
  output logic [7:0]  app_status
);

  typedef enum logic [1:0] {
    S_LO = 2'd0,
    S_HI = 2'd1,
    S_CL = 2'd2,
    S_CH = 2'd3
  } state_t;

  localparam logic [15:0] LAST_WORD = 16'(PKT_WORDS - 1);

  state_t      state_q, state_d;
  logic [7:0]  word_hi_q, word_hi_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [7:0]  pkt_cnt_q, pkt_cnt_d;
`ifdef WCONV_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif

  logic mode_ok;
  logic wr, rd, last_byte;

  assign mode_ok    = (app_mode == 8'h00) || (app_mode == 8'h01);
  assign app_status = pkt_cnt_q;

  // NOTE: every signal written below gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    word_hi_d  = word_hi_q;
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
`ifdef WCONV_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    dout       = din[7:0];
    wr         = 1'b0;
    rd         = 1'b0;
    last_byte  = 1'b0;

    case (state_q)
      S_LO: begin
        dout = din[7:0];
        wr   = ~empty & ~full & mode_ok;
        rd   = wr;
        if (wr) begin
          word_hi_d = din[15:8];
`ifdef WCONV_CHECKSUM_EN
          csum_d    = csum_q + din;
`endif
          state_d   = S_HI;
        end
      end
      // The high byte of a split word always completes, whatever app_mode says.
      S_HI: begin
        dout = word_hi_q;
        wr   = ~full;
        if (wr) begin
          if (word_cnt_q != LAST_WORD) begin
            word_cnt_d = word_cnt_q + 16'd1;
            state_d    = S_LO;
          end else begin
            word_cnt_d = '0;
`ifdef WCONV_CHECKSUM_EN
            state_d    = S_CL;
`else
            last_byte  = 1'b1;
            pkt_cnt_d  = pkt_cnt_q + 8'd1;
            state_d    = S_LO;
`endif
          end
        end
      end
`ifdef WCONV_CHECKSUM_EN
      S_CL: begin
        dout = csum_q[7:0];
        wr   = ~full;
        if (wr) state_d = S_CH;
      end
      S_CH: begin
        dout      = csum_q[15:8];
        wr        = ~full;
        last_byte = wr;
        if (wr) begin
          csum_d    = '0;
          pkt_cnt_d = pkt_cnt_q + 8'd1;
          state_d   = S_LO;
        end
      end
`endif
      default: state_d = S_LO;
    endcase
  end

  // Strobes are forced low during reset so nothing leaves the block while it is being cleared.
  assign wr_en   = wr & ~RESET;
  assign rd_en   = rd & ~RESET;
  assign pkt_end = last_byte & ~RESET;

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_LO;
      word_hi_q  <= '0;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
`ifdef WCONV_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_hi_q  <= word_hi_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
`ifdef WCONV_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_width_conv_16to8.sv
// Scoreboard bench for width_conv_16to8: dut0 with PKT_WORDS=2, dut1 with PKT_WORDS=1 for counter wrap.
// Expected bytes are built from pushed words; follows WCONV_CHECKSUM_EN like the design.
module tb_width_conv_16to8;

  typedef struct packed {
    logic [7:0] b;
    logic       e;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic [15:0] din0, din1;
  logic        empty0, empty1;
  logic        rd_en0, rd_en1;
  logic [7:0]  dout0, dout1;
  logic        wr_en0, wr_en1;
  logic        full0, full1;
  logic        pkt_end0, pkt_end1;
  logic [7:0]  app_mode0, app_mode1;
  logic [7:0]  app_status0, app_status1;

  width_conv_16to8 #(.PKT_WORDS(2)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .din(din0), .empty(empty0), .rd_en(rd_en0),
    .dout(dout0), .wr_en(wr_en0), .full(full0), .pkt_end(pkt_end0),
    .app_mode(app_mode0), .app_status(app_status0)
  );

  width_conv_16to8 #(.PKT_WORDS(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .din(din1), .empty(empty1), .rd_en(rd_en1),
    .dout(dout1), .wr_en(wr_en1), .full(full1), .pkt_end(pkt_end1),
    .app_mode(app_mode1), .app_status(app_status1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] src0[$];
  logic [15:0] src1[$];
  exp_t        sb0[$];
  exp_t        sb1[$];
  int          m_cnt[2];
  logic [15:0] m_csum[2];
  int          checks = 0;
  int          errors = 0;
  int          pkt_ends1 = 0;
  logic        last_wr0, last_rd0;
  logic [7:0]  last_dout0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model of one packetiser: records the source word and the bytes it must become.
  task automatic load(input int which, input logic [15:0] w);
    int   pw;
    logic last;
    exp_t lo, hi;
    pw   = (which == 0) ? 2 : 1;
    last = (m_cnt[which] == pw - 1);
    lo   = '{b: w[7:0], e: 1'b0};
`ifdef WCONV_CHECKSUM_EN
    hi   = '{b: w[15:8], e: 1'b0};
`else
    hi   = '{b: w[15:8], e: last};
`endif
    if (which == 0) begin
      src0.push_back(w); sb0.push_back(lo); sb0.push_back(hi);
    end else begin
      src1.push_back(w); sb1.push_back(lo); sb1.push_back(hi);
    end
`ifdef WCONV_CHECKSUM_EN
    m_csum[which] = m_csum[which] + w;
    if (last) begin
      lo = '{b: m_csum[which][7:0], e: 1'b0};
      hi = '{b: m_csum[which][15:8], e: 1'b1};
      if (which == 0) begin sb0.push_back(lo); sb0.push_back(hi); end
      else            begin sb1.push_back(lo); sb1.push_back(hi); end
      m_csum[which] = '0;
    end
`endif
    m_cnt[which] = last ? 0 : m_cnt[which] + 1;
  endtask

  // One clock: drive at negedge, observe just before posedge, retire pops after it.
  task automatic step();
    exp_t e;
    logic r0, r1;
    din0   = (src0.size() > 0) ? src0[0] : 16'hDEAD;
    empty0 = (src0.size() == 0);
    din1   = (src1.size() > 0) ? src1[0] : 16'hDEAD;
    empty1 = (src1.size() == 0);
    #1;
    last_wr0   = wr_en0;
    last_rd0   = rd_en0;
    last_dout0 = dout0;
    if (wr_en0) begin
      if (sb0.size() == 0) check("dut0_extra_write", {24'd0, dout0}, 32'hFFFF_FFFF);
      else begin
        e = sb0.pop_front();
        check("dut0_dout", {24'd0, dout0}, {24'd0, e.b});
        check("dut0_pkt_end", {31'd0, pkt_end0}, {31'd0, e.e});
      end
    end
    check("dut0_pkt_end_qual", {31'd0, pkt_end0 & ~wr_en0}, 32'd0);
    check("dut0_rd_without_wr", {31'd0, rd_en0 & ~wr_en0}, 32'd0);
    check("dut0_wr_while_full", {31'd0, wr_en0 & full0}, 32'd0);
    if (wr_en1) begin
      if (sb1.size() == 0) check("dut1_extra_write", {24'd0, dout1}, 32'hFFFF_FFFF);
      else begin
        e = sb1.pop_front();
        check("dut1_dout", {24'd0, dout1}, {24'd0, e.b});
        check("dut1_pkt_end", {31'd0, pkt_end1}, {31'd0, e.e});
      end
    end
    check("dut1_rd_without_wr", {31'd0, rd_en1 & ~wr_en1}, 32'd0);
    if (wr_en1 && pkt_end1) pkt_ends1++;
    r0 = rd_en0;
    r1 = rd_en1;
    @(posedge CLK);
    if (r0 && src0.size() > 0) void'(src0.pop_front());
    if (r1 && src1.size() > 0) void'(src1.pop_front());
    @(negedge CLK);
  endtask

  task automatic drain(output int cycles);
    cycles = 0;
    while ((sb0.size() > 0 || sb1.size() > 0) && cycles < 4000) begin
      step();
      cycles++;
    end
    if (sb0.size() > 0 || sb1.size() > 0)
      check("drain_timeout", sb0.size() + sb1.size(), 32'd0);
  endtask

  int cyc;
  int exp_basic_cycles;

  initial begin
    RESET = 1'b1;
    full0 = 1'b0; full1 = 1'b0;
    app_mode0 = 8'h00; app_mode1 = 8'h00;
    din0 = '0; din1 = '0; empty0 = 1'b1; empty1 = 1'b1;
    m_cnt[0] = 0; m_cnt[1] = 0; m_csum[0] = '0; m_csum[1] = '0;
`ifdef WCONV_CHECKSUM_EN
    exp_basic_cycles = 6;
`else
    exp_basic_cycles = 4;
`endif
    @(negedge CLK);

    // Reset holds all strobes low even with data waiting.
    src0.push_back(16'h5555);
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_wr_en", {31'd0, last_wr0}, 32'd0);
      check("reset_rd_en", {31'd0, last_rd0}, 32'd0);
      check("reset_app_status", {24'd0, app_status0}, 32'd0);
    end
    src0.delete();
    RESET = 1'b0;

    // Basic conversion, back to back.
    load(0, 16'h1234); load(0, 16'hABCD);
    drain(cyc);
    check("basic_cycles", cyc, exp_basic_cycles);
    check("basic_app_status", {24'd0, app_status0}, 32'd1);

    // Checksum wrap-around words.
    load(0, 16'hFFFF); load(0, 16'h0003);
    drain(cyc);
    check("csum_app_status", {24'd0, app_status0}, 32'd2);

    // Backpressure while holding the high byte.
    load(0, 16'h1234); load(0, 16'h5678);
    step();
    check("bp_low_written", {31'd0, last_wr0}, 32'd1);
    full0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall_wr", {31'd0, last_wr0}, 32'd0);
      check("bp_stall_rd", {31'd0, last_rd0}, 32'd0);
      check("bp_stall_dout", {24'd0, last_dout0}, 32'h12);
    end
    full0 = 1'b0;
    step();
    check("bp_release_wr", {31'd0, last_wr0}, 32'd1);
    check("bp_release_dout", {24'd0, last_dout0}, 32'h12);
    drain(cyc);
    check("bp_app_status", {24'd0, app_status0}, 32'd3);

    // Mode gating: blocked start, then a split word still finishes.
    load(0, 16'h1111); load(0, 16'h2222);
    app_mode0 = 8'h02;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mode_idle_wr", {31'd0, last_wr0}, 32'd0);
      check("mode_idle_rd", {31'd0, last_rd0}, 32'd0);
    end
    app_mode0 = 8'h00;
    step();
    check("mode_low_wr", {31'd0, last_wr0}, 32'd1);
    app_mode0 = 8'h02;
    step();
    check("mode_high_completes", {31'd0, last_wr0}, 32'd1);
    check("mode_high_dout", {24'd0, last_dout0}, 32'h11);
    for (int i = 0; i < 2; i++) begin
      step();
      check("mode_after_idle", {31'd0, last_wr0}, 32'd0);
    end
    app_mode0 = 8'h01;
    drain(cyc);
    check("mode_app_status", {24'd0, app_status0}, 32'd4);

    // Reset after the low byte: high byte dropped, fresh packet follows.
    load(0, 16'h1234);
    step();
    check("rst_mid_low_wr", {31'd0, last_wr0}, 32'd1);
    RESET = 1'b1;
    sb0.delete();
    m_cnt[0] = 0;
    m_csum[0] = '0;
    step();
    check("rst_mid_wr", {31'd0, last_wr0}, 32'd0);
    check("rst_mid_app_status", {24'd0, app_status0}, 32'd0);
    RESET = 1'b0;
    load(0, 16'h5678); load(0, 16'h9ABC);
    drain(cyc);
    check("rst_mid_new_packet", {24'd0, app_status0}, 32'd1);

    // 256 single-word packets wrap the packet counter.
    for (int i = 0; i < 256; i++) load(1, 16'(i * 16'h0101 + 16'h0F00));
    drain(cyc);
    check("wrap_app_status", {24'd0, app_status1}, 32'd0);
    check("wrap_pkt_end_count", pkt_ends1, 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
